// File: rtl/gate_guard_pkg.sv
// +----------------------------------------------------------------------+
// | gate_guard_pkg : shared pmic types and default gate-guard constants   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package gate_guard_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        HS_ON   = 3'd1,
        LS_ON   = 3'd2,
        DEAD    = 3'd3,
        FAULT   = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    localparam int DEF_DEAD_CYCLES   = 5;
    localparam int DEF_MAX_ON_CYCLES = 300;
    localparam int DEF_RETRY_CYCLES  = 4096;
    localparam int DEF_MAX_RETRIES   = 3;

endpackage

`default_nettype wire

// File: rtl/gate_guard_sync_2ff.sv
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser, active-low asynchronous reset       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/gate_guard.sv
// +----------------------------------------------------------------------+
// | gate_guard : gate-drive protection (non-overlap, dead time, max-on,   |
// |              over-current retry and lockout)          Revision : 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_guard
    import gate_guard_pkg::*;
#(
    parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
    parameter int MAX_ON_CYCLES = DEF_MAX_ON_CYCLES,
    parameter int RETRY_CYCLES  = DEF_RETRY_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic hs_req,
    input  logic ls_req,
    input  logic ocp,
    output logic hs_gate,
    output logic ls_gate,
    output logic fault,
    output logic lockout,
    output logic overlap_err,
    output logic max_on_err
);

    localparam int c_deadW  = $clog2(DEAD_CYCLES + 1);
    localparam int c_onW    = $clog2(MAX_ON_CYCLES + 1);
    localparam int c_tmrW   = $clog2(RETRY_CYCLES + 1);
    localparam int c_retryW = $clog2(MAX_RETRIES + 1);

    localparam logic [c_deadW-1:0]  c_deadLast  = c_deadW'(DEAD_CYCLES - 1);
    localparam logic [c_onW-1:0]    c_onMax     = c_onW'(MAX_ON_CYCLES);
    localparam logic [c_tmrW-1:0]   c_tmrLast   = c_tmrW'(RETRY_CYCLES - 1);
    localparam logic [c_retryW-1:0] c_retryMax  = c_retryW'(MAX_RETRIES);
    localparam logic [c_retryW-1:0] c_retryLast = c_retryW'(MAX_RETRIES - 1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_deadW-1:0]  r_dead;
    logic [c_onW-1:0]    r_onTime;
    logic [c_tmrW-1:0]   r_retryTmr;
    logic [c_retryW-1:0] r_retries;
    logic                r_hsBlock;
    logic                r_hsGate;
    logic                r_lsGate;
    logic                r_fault;
    logic                r_lockout;
    logic                r_overlapErr;
    logic                r_maxOnErr;

    logic w_ocpS;
    logic w_ocpTrip;
    logic w_maxOnTrip;
    logic w_hsOnly;
    logic w_lsOnly;
    logic w_deadDone;
    logic w_tmrDone;

    sync_2ff #(
        .WIDTH (1)
    ) u_ocpSync (
        .clk   (clk),
        .reset (reset),
        .d     (ocp),
        .q     (w_ocpS)
    );

    // Over-current only trips from the switching states; FAULT/LOCKOUT own their exit.
    assign w_ocpTrip   = w_ocpS && (r_state != FAULT) && (r_state != LOCKOUT);
    assign w_maxOnTrip = !w_ocpTrip && enable && (r_state == HS_ON) && (r_onTime == c_onMax);
    assign w_hsOnly    = hs_req && !ls_req && !r_hsBlock;
    assign w_lsOnly    = ls_req && !hs_req;
    assign w_deadDone  = (r_dead == c_deadLast);
    assign w_tmrDone   = (r_retryTmr == c_tmrLast);

    always_comb begin
        w_stateNext = r_state;
        if (w_ocpTrip) begin
            w_stateNext = FAULT;
        end else if (!enable) begin
            w_stateNext = (r_state == LOCKOUT) ? OFF : DEAD;
        end else begin
            case (r_state)
                OFF: begin
                    if (w_hsOnly)      w_stateNext = HS_ON;
                    else if (w_lsOnly) w_stateNext = LS_ON;
                end
                HS_ON: begin
                    if (w_maxOnTrip || !hs_req || ls_req) w_stateNext = DEAD;
                end
                LS_ON: begin
                    if (!ls_req || hs_req) w_stateNext = DEAD;
                end
                DEAD: begin
                    if (w_deadDone) begin
                        if (w_hsOnly)      w_stateNext = HS_ON;
                        else if (w_lsOnly) w_stateNext = LS_ON;
                        else               w_stateNext = OFF;
                    end
                end
                FAULT: begin
                    if (w_tmrDone && !w_ocpS)
                        w_stateNext = (r_retries == c_retryLast) ? LOCKOUT : DEAD;
                end
                LOCKOUT: w_stateNext = LOCKOUT;
                default: w_stateNext = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= OFF;
            r_dead       <= '0;
            r_onTime     <= '0;
            r_retryTmr   <= '0;
            r_retries    <= '0;
            r_hsBlock    <= 1'b0;
            r_hsGate     <= 1'b0;
            r_lsGate     <= 1'b0;
            r_fault      <= 1'b0;
            r_lockout    <= 1'b0;
            r_overlapErr <= 1'b0;
            r_maxOnErr   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_hsGate  <= (w_stateNext == HS_ON);
            r_lsGate  <= (w_stateNext == LS_ON);
            r_fault   <= (w_stateNext == FAULT) || (w_stateNext == LOCKOUT);
            r_lockout <= (w_stateNext == LOCKOUT);

            // Dead count restarts on any entry and while enable is held low.
            if ((r_state == DEAD) && (w_stateNext == DEAD) && enable && !w_deadDone)
                r_dead <= r_dead + 1'b1;
            else
                r_dead <= '0;

            if (w_stateNext == HS_ON) begin
                if (r_state != HS_ON)
                    r_onTime <= c_onW'(1);
                else if (r_onTime != c_onMax)
                    r_onTime <= r_onTime + 1'b1;
            end else begin
                r_onTime <= '0;
            end

            if ((r_state == FAULT) && (w_stateNext == FAULT) && !w_tmrDone)
                r_retryTmr <= r_retryTmr + 1'b1;
            else
                r_retryTmr <= '0;

            if (!enable && !w_ocpTrip)
                r_retries <= '0;
            else if ((r_state == FAULT) && w_tmrDone && !w_ocpS && (r_retries != c_retryMax))
                r_retries <= r_retries + 1'b1;

            if (w_maxOnTrip)
                r_hsBlock <= 1'b1;
            else if (!hs_req)
                r_hsBlock <= 1'b0;

            if (w_maxOnTrip)
                r_maxOnErr <= 1'b1;
            if (hs_req && ls_req)
                r_overlapErr <= 1'b1;
        end
    end

    assign hs_gate     = r_hsGate;
    assign ls_gate     = r_lsGate;
    assign fault       = r_fault;
    assign lockout     = r_lockout;
    assign overlap_err = r_overlapErr;
    assign max_on_err  = r_maxOnErr;

endmodule

`default_nettype wire

// File: tb/tb_gate_guard.sv
// +----------------------------------------------------------------------+
// | tb_gate_guard : directed self-checking bench for gate_guard           |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gate_guard;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic hs_req;
    logic ls_req;
    logic ocp;
    logic hs_gate;
    logic ls_gate;
    logic fault;
    logic lockout;
    logic overlap_err;
    logic max_on_err;

    int   nVec = 0;
    int   nMis = 0;
    int   cnt;
    logic bothHigh = 1'b0;

    gate_guard u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hs_req      (hs_req),
        .ls_req      (ls_req),
        .ocp         (ocp),
        .hs_gate     (hs_gate),
        .ls_gate     (ls_gate),
        .fault       (fault),
        .lockout     (lockout),
        .overlap_err (overlap_err),
        .max_on_err  (max_on_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hs_gate && ls_gate) bothHigh <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ocpFault();
        ocp = 1'b1;
        repeat (3) tick();
        ocp = 1'b0;
        repeat (4096) tick();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; hs_req = 1'b0; ls_req = 1'b0; ocp = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({hs_gate, ls_gate, fault, lockout, overlap_err, max_on_err}), 32'd0);
        enable = 1'b1;
        reset  = 1'b1;
        repeat (2) tick();
        chk("idle_gates", 32'({hs_gate, ls_gate}), 32'd0);

        // alternating PWM
        hs_req = 1'b1; cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); cnt += int'(hs_gate); end
        chk("alt_hs_high", cnt, 32'd20);
        hs_req = 1'b0; cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (!hs_gate && !ls_gate) cnt++; end
        chk("alt_dead_gap", cnt, 32'd5);
        ls_req = 1'b1; cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); cnt += int'(ls_gate); end
        chk("alt_ls_high", cnt, 32'd20);
        ls_req = 1'b0;
        tick();
        chk("alt_ls_off", 32'(ls_gate), 32'd0);
        repeat (8) tick();

        // fast swap
        hs_req = 1'b1;
        repeat (10) tick();
        hs_req = 1'b0; ls_req = 1'b1;
        tick();
        chk("swap_hs_off", 32'(hs_gate), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ls_gate) break;
            cnt++;
        end
        chk("swap_gap", cnt, 32'd4);
        chk("swap_ls_on", 32'(ls_gate), 32'd1);
        chk("swap_no_overlap_err", 32'(overlap_err), 32'd0);
        ls_req = 1'b0;
        repeat (8) tick();

        // overlapping requests from OFF
        hs_req = 1'b1; ls_req = 1'b1; cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); cnt += int'(hs_gate) + int'(ls_gate); end
        chk("ovl_gates_off", cnt, 32'd0);
        chk("ovl_err", 32'(overlap_err), 32'd1);
        hs_req = 1'b0; ls_req = 1'b0;
        repeat (2) tick();

        // max on-time
        hs_req = 1'b1; cnt = 0;
        for (int i = 0; i < 400; i++) begin tick(); cnt += int'(hs_gate); end
        chk("maxon_high_cycles", cnt, 32'd300);
        chk("maxon_err", 32'(max_on_err), 32'd1);
        chk("maxon_blocked", 32'(hs_gate), 32'd0);
        hs_req = 1'b0;
        repeat (2) tick();
        hs_req = 1'b1;
        tick();
        chk("maxon_fresh_req", 32'(hs_gate), 32'd1);
        hs_req = 1'b0;
        repeat (8) tick();

        // OCP trip and retry
        hs_req = 1'b1;
        repeat (3) tick();
        ocp = 1'b1;
        tick();
        tick();
        chk("ocp_edge1_still_on", 32'(hs_gate), 32'd1);
        tick();
        chk("ocp_edge2_gates", 32'({hs_gate, ls_gate, fault}), 32'b001);
        ocp = 1'b0;
        repeat (4095) tick();
        chk("retry_still_fault", 32'(fault), 32'd1);
        tick();
        chk("retry_fault_clear", 32'({fault, hs_gate}), 32'd0);
        repeat (4) tick();
        chk("retry_dead_hold", 32'(hs_gate), 32'd0);
        tick();
        chk("retry_resume", 32'(hs_gate), 32'd1);

        // lockout after three faults
        ocpFault();
        chk("fault2_no_lockout", 32'({fault, lockout}), 32'd0);
        ocpFault();
        chk("fault3_lockout", 32'({fault, lockout}), 32'b11);
        repeat (10) tick();
        chk("lockout_hs_held", 32'(hs_gate), 32'd0);
        hs_req = 1'b0; ls_req = 1'b1;
        repeat (10) tick();
        chk("lockout_ls_held", 32'(ls_gate), 32'd0);
        ls_req = 1'b0;
        enable = 1'b0;
        tick();
        chk("enable_clears_lockout", 32'({fault, lockout}), 32'd0);
        enable = 1'b1; hs_req = 1'b1;
        tick();
        chk("resume_after_lockout", 32'(hs_gate), 32'd1);
        ocpFault();
        chk("history_cleared", 32'({fault, lockout}), 32'd0);

        // asynchronous reset mid HS_ON
        repeat (6) tick();
        chk("pre_reset_hs_on", 32'(hs_gate), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({hs_gate, ls_gate, fault, lockout, overlap_err, max_on_err}), 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("post_reset_hs", 32'({hs_gate, ls_gate}), 32'b10);

        chk("never_both_high", 32'(bothHigh), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

`default_nettype wire
